tpum_ctrl: RTL

Parametrised operation controller for the TPUM datapath. It sequences operand loading from the crossbar (xbox) read port into `NUM_OPERANDS` operand registers and dispatches one of three compute engines (GEMM, BNN, PUM). It hands the result to the xbox write port and repeats this for a programmed number of iterations. It sits between the host command interface (`start`/`op_mode`) and the xbox/engine datapath, and supports abort and illegal-command reporting.

---
 rtl/tpum_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tpum_ctrl.sv
// tpum_ctrl: operation controller for the TPUM datapath.
// Loads NUM_OPERANDS operands from the xbox read port, runs one engine
// (GEMM/BNN/PUM), hands the result to the xbox write port, and repeats
// for iter_count iterations. Supports abort and illegal-command reporting.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; illegal commands raise err next cycle
// S_LOAD   | loading operand idx on each xbox_read_valid
// S_COMPUTE| engine running, waiting for compute_done
// S_WRITE  | result offered to xbox until xbox_write_isready
// S_DONE   | one-cycle completion pulse, then back to idle
module tpum_ctrl #(
    parameter int NUM_OPERANDS = 2,
    parameter int CNT_W        = 8,
    parameter int IDX_W        = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              op_mode,
    input  logic [CNT_W-1:0]        iter_count,
    input  logic                    abort,
    input  logic                    xbox_read_valid,
    input  logic                    compute_done,
    input  logic                    xbox_write_isready,
    output logic [NUM_OPERANDS-1:0] reg_rd_en,
    output logic [2:0]              engine_sel,
    output logic                    compute_en,
    output logic                    xbox_write_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_LOAD    = 5'b00010,
        S_COMPUTE = 5'b00100,
        S_WRITE   = 5'b01000,
        S_DONE    = 5'b10000
    } state_t;

    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_OPERANDS - 1);
    localparam logic [NUM_OPERANDS-1:0] ONE_HOT0 = NUM_OPERANDS'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic             cmd_legal;
    logic [2:0]       sel_decoded;

    assign cmd_legal = (op_mode != 2'b00) && (iter_count != '0);

    // Map the host op_mode onto the one-hot engine select.
    always_comb begin
        sel_decoded = 3'b000;
        case (op_mode)
            2'b01:   sel_decoded = 3'b001;
            2'b10:   sel_decoded = 3'b010;
            2'b11:   sel_decoded = 3'b100;
            default: sel_decoded = 3'b000;
        endcase
    end

    // State, operand index, iteration counter, engine select and err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; abort overrides every other transition outside idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cmd_legal) begin
                        sel_d   = sel_decoded;
                        cnt_d   = iter_count;
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (xbox_read_valid) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (compute_done) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (xbox_write_isready) begin
                    // The counter bottoms out at 1 so a full-scale count never wraps.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
                sel_d   = 3'b000;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
                sel_d   = 3'b000;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            sel_d   = 3'b000;
            err_d   = 1'b0;
        end
    end

    // Operand load enable follows xbox_read_valid in the same cycle.
    always_comb begin
        reg_rd_en = '0;
        if ((state_q == S_LOAD) && xbox_read_valid) begin
            reg_rd_en = ONE_HOT0 << idx_q;
        end
    end

    assign engine_sel       = sel_q;
    assign compute_en       = (state_q == S_COMPUTE);
    assign xbox_write_ready = (state_q == S_WRITE);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign err              = err_q;

endmodule
